// File: rtl/piso_serializer_if.sv
// Handshake/serial-link bundle for piso_serializer: parallel load side plus 1-bit serial output side.
interface piso_serializer_if #(
    parameter int unsigned WIDTH = 4
);
    logic [WIDTH-1:0] din;
    logic             load_valid;
    logic             load_ready;
    logic             sout;
    logic             sout_valid;
    logic             frame_start;
    logic             busy;

    modport master (
        output din, load_valid,
        input  load_ready, sout, sout_valid, frame_start, busy
    );

    modport slave (
        input  din, load_valid,
        output load_ready, sout, sout_valid, frame_start, busy
    );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter: one WIDTH-bit word per frame, one bit per clk, frame_start on bit 0.
// Optional feature: define PISO_PARITY_EN to append one even-parity bit after the data bits.
module piso_serializer #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MSB_FIRST = 1
) (
    input logic                clk,
    input logic                rst,
    piso_serializer_if.slave   bus
);

    localparam int unsigned CNT_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned OUT_IDX = (MSB_FIRST != 0) ? WIDTH - 1 : 0;

`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_t;
`else
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;
`endif

    state_t           r_state;
    logic [WIDTH-1:0] r_shreg;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sout;
    logic             r_sout_valid;
    logic             r_frame_start;
    logic             r_busy;
`ifdef PISO_PARITY_EN
    logic             r_parity;
    logic             w_parity_nxt;
`endif

    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_shreg_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_last;
    logic             w_load_ready;
    logic             w_accept;
    logic             w_sout_nxt;

    // Next-state, datapath and load_ready decode; outputs are registered from the next state.
    always_comb begin
        w_state_nxt = r_state;
        w_shreg_nxt = r_shreg;
        w_cnt_nxt   = '0;
        w_sout_nxt  = 1'b0;
        w_last      = (r_state == ST_SHIFT) && (r_cnt == CNT_W'(WIDTH - 1));
`ifdef PISO_PARITY_EN
        w_parity_nxt = r_parity;
        w_load_ready = (r_state == ST_IDLE) || (r_state == ST_PARITY);
`else
        w_load_ready = (r_state == ST_IDLE) || w_last;
`endif
        w_accept = bus.load_valid && w_load_ready;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (MSB_FIRST != 0) w_shreg_nxt = {r_shreg[WIDTH-2:0], 1'b0};
                else                w_shreg_nxt = {1'b0, r_shreg[WIDTH-1:1]};
                if (!w_last) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end else begin
`ifdef PISO_PARITY_EN
                    w_state_nxt = ST_PARITY;
`else
                    w_state_nxt = w_accept ? ST_SHIFT : ST_IDLE;
`endif
                end
            end
`ifdef PISO_PARITY_EN
            ST_PARITY: begin
                w_state_nxt = w_accept ? ST_SHIFT : ST_IDLE;
            end
`endif
            default: w_state_nxt = ST_IDLE;
        endcase

        // A new word overrides the shift and restarts the bit count.
        if (w_accept) begin
            w_shreg_nxt = bus.din;
            w_cnt_nxt   = '0;
`ifdef PISO_PARITY_EN
            w_parity_nxt = ^bus.din;
`endif
        end

        case (w_state_nxt)
            ST_SHIFT:  w_sout_nxt = w_shreg_nxt[OUT_IDX];
`ifdef PISO_PARITY_EN
            ST_PARITY: w_sout_nxt = r_parity;
`endif
            default:   w_sout_nxt = 1'b0;
        endcase
    end

    // State and output registers; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_shreg       <= '0;
            r_cnt         <= '0;
            r_sout        <= 1'b0;
            r_sout_valid  <= 1'b0;
            r_frame_start <= 1'b0;
            r_busy        <= 1'b0;
`ifdef PISO_PARITY_EN
            r_parity      <= 1'b0;
`endif
        end else begin
            r_state       <= w_state_nxt;
            r_shreg       <= w_shreg_nxt;
            r_cnt         <= w_cnt_nxt;
            r_sout        <= w_sout_nxt;
            r_sout_valid  <= (w_state_nxt != ST_IDLE);
            r_frame_start <= w_accept;
            r_busy        <= (w_state_nxt != ST_IDLE);
`ifdef PISO_PARITY_EN
            r_parity      <= w_parity_nxt;
`endif
        end
    end

    assign bus.load_ready  = w_load_ready;
    assign bus.sout        = r_sout;
    assign bus.sout_valid  = r_sout_valid;
    assign bus.frame_start = r_frame_start;
    assign bus.busy        = r_busy;

endmodule
